johnson_rx: RTL and testbench
=============================

Name: johnson_rx

Overview:
Receiver/checker for the Johnson-counter code stream produced by our Johnson counter block. It samples an N-bit Johnson code, validates and decodes it to a state index, and tracks step-to-step sequencing (forward, backward, hold or skip). It reports lock status, step direction and error counts. It sits behind the tt_um pin wrapper, with code_in driven from ui_in and status driven onto uo_out/uio_out.

Parameters:
N, 8, Johnson code width; 2N states; index width IW = clog2(2N).
LOCK_CNT, 4, consecutive good steps (forward or backward) needed to assert locked.
UNLOCK_ERR, 2, consecutive errors while LOCKED that drop lock.
ECW, 8, error counter width (saturating).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
code_valid  in  1  code_in sample strobe.
code_in  in  N  Johnson code sample.
err_clr  in  1  clears err_count.
index  out  IW  last valid decoded index.
index_valid  out  1  one-cycle pulse: index updated.
dir  out  1  last step direction: 0 = forward, 1 = backward.
locked  out  1  sequence locked.
err_pulse  out  1  one-cycle error pulse.
err_code  out  2  type of the latest error: 01 = invalid code, 10 = skip; held until the next error.
err_count  out  ECW  saturating error total.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high. All state is reset synchronously.
- Reset values: index 0, index_valid 0, dir 0, locked 0, err_pulse 0, err_code 00, err_count 0, FSM SEARCH, good_cnt 0, bad_cnt 0, have_ref 0. Asserting rst mid-sequence discards the pipeline contents; the first sample after reset re-seeds the reference.
- Code sequence: forward next = {q[N-2:0], ~q[N-1]}. For N=8: 00 -> 01 -> 03 -> ... -> FF -> FE -> ... -> 80 -> 00.
- Validity: a code is valid iff at most one adjacent-bit pair differs (q[i] != q[i+1], i = 0..N-2). This yields exactly 2N valid codes.
- Decode: if q[N-1] = 0 then k = popcount(q), else k = 2N - popcount(q).
- Pipeline: stage 1 registers code_valid, the valid flag and k. Stage 2 compares k against the reference and updates the FSM and all outputs. Latency is 2 cycles from code_valid to index_valid/err_pulse. Full throughput: one sample per cycle, no backpressure. Cycles with code_valid = 0 change nothing.
- Step classification (valid code, reference present), with delta = (k - ref) mod 2N:
  - 0 = hold: no pulse, no error, counters unchanged.
  - 1 = forward step: dir <= 0.
  - 2N-1 = backward step: dir <= 1.
  - any other value = skip error.
- Wrap: 15 -> 0 is forward and 0 -> 15 is backward (N=8).
- Reference update: every valid code updates ref, index and index_valid, including on a skip. An invalid code leaves ref and index unchanged; index_valid stays 0.
- FSM:
  - SEARCH: the first valid code sets ref, sets have_ref and moves to TRACK with good_cnt = 0. An invalid code raises an error and stays in SEARCH.
  - TRACK: each step increments good_cnt. When good_cnt reaches LOCK_CNT, go to LOCKED and assert locked in the same cycle as that step's index_valid. An invalid code goes to SEARCH with have_ref = 0. A skip restarts TRACK with good_cnt = 0.
  - LOCKED: a step clears bad_cnt. Any error increments bad_cnt. When bad_cnt reaches UNLOCK_ERR, go to SEARCH, deassert locked and clear have_ref. Holds leave bad_cnt unchanged.
- Errors: each error raises err_pulse for 1 cycle, updates err_code and increments err_count, saturating at 2^ECW - 1.
- err_clr: clears err_count. If err_clr coincides with a new error, err_count becomes 1.
- Simultaneous skip and lock threshold cannot occur, because a skip is not a step.

Decomposition:
- johnson_pkg:
  - state enum {SEARCH, TRACK, LOCKED}
  - err_code constants ERR_NONE, ERR_INVALID, ERR_SKIP
  - step-class enum {HOLD, FWD, BWD, SKIP}
- Sub-module johnson_decode: combinational, code_in -> {valid, k}, parameterised by N. It is instantiated once in stage 1.

Test Plan:
- Reset: hold rst = 1 for 2 cycles mid-stream -> all outputs at reset values. The next sample 0x03 gives index = 2, locked = 0.
- Forward lock: feed 00, 01, 03, 07, 0F on consecutive cycles -> index_valid pulses with indices 0..4, dir = 0. locked rises 2 cycles after the 0F sample.
- Wrap/backward: when locked at 80 (k = 15), feed 00 -> forward, index 0. Then feed 80 -> dir = 1, index 15. No errors.
- Invalid code while locked: feed 0x05 -> err_pulse, err_code = 01, err_count = 1, locked stays 1, index unchanged. A second consecutive 0x05 -> locked = 0, FSM = SEARCH.
- Skip: from 03 (k = 2) feed 0F (k = 4) -> err_code = 10, index = 4. In TRACK this sets good_cnt = 0.
- Counter edges:
  - 300 invalid samples -> err_count = 255 (saturated).
  - err_clr coincident with an error -> err_count = 1.
  - Repeated code or code_valid = 0 -> no pulses.

Source files
------------

// File: rtl/johnson_pkg.sv
`default_nettype none
// ============================================================================
// Module      : johnson_pkg
// Description : Shared types and error codes for the Johnson code receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package johnson_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        FWD  = 2'd1,
        BWD  = 2'd2,
        SKIP = 2'd3
    } step_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_INVALID = 2'b01;
    localparam logic [1:0] ERR_SKIP    = 2'b10;

endpackage
`default_nettype wire

// File: rtl/johnson_decode.sv
`default_nettype none
// ============================================================================
// Module      : johnson_decode
// Description : Combinational Johnson code validity check and index decode.
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  i_code,
    output logic          o_valid,
    output logic [IW-1:0] o_k
);

    localparam logic [IW-1:0] c_NS = IW'(2 * N);

    logic [N-2:0]  w_diff;
    logic [N-2:0]  w_diff_m1;
    logic [IW-1:0] w_pop;

    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_pair
            assign w_diff[gi] = i_code[gi] ^ i_code[gi+1];
        end
    endgenerate

    // At most one adjacent-pair transition: clearing the lowest set bit leaves zero
    assign w_diff_m1 = w_diff - (N-1)'(1);
    assign o_valid   = ((w_diff & w_diff_m1) == '0);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + IW'(i_code[i]);
        end
    end

    // c_NS wraps to zero when 2N is a power of two, which still yields 2N - pop modulo 2^IW
    assign o_k = i_code[N-1] ? (c_NS - w_pop) : w_pop;

endmodule
`default_nettype wire

// File: rtl/johnson_rx.sv
`default_nettype none
// ============================================================================
// Module      : johnson_rx
// Description : Johnson code stream checker: decode, step tracking, lock, errors.
// Revision    : 1.0 - initial release
// ============================================================================
module johnson_rx
    import johnson_pkg::*;
#(
    parameter  int N          = 8,
    parameter  int LOCK_CNT   = 4,
    parameter  int UNLOCK_ERR = 2,
    parameter  int ECW        = 8,
    localparam int IW         = $clog2(2 * N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           code_valid,
    input  logic [N-1:0]   code_in,
    input  logic           err_clr,
    output logic [IW-1:0]  index,
    output logic           index_valid,
    output logic           dir,
    output logic           locked,
    output logic           err_pulse,
    output logic [1:0]     err_code,
    output logic [ECW-1:0] err_count
);

    localparam int              c_GW     = $clog2(LOCK_CNT + 1);
    localparam int              c_BW     = $clog2(UNLOCK_ERR + 1);
    localparam logic [c_GW-1:0] c_LOCK   = c_GW'(LOCK_CNT);
    localparam logic [c_BW-1:0] c_UNLOCK = c_BW'(UNLOCK_ERR);
    localparam logic [IW-1:0]   c_NS     = IW'(2 * N);
    localparam logic [IW-1:0]   c_ONE    = IW'(1);
    localparam logic [IW-1:0]   c_LAST   = IW'(2 * N - 1);

    logic            w_dec_valid;
    logic [IW-1:0]   w_dec_k;
    logic [IW-1:0]   w_delta;
    step_t           w_step;
    logic            w_err;
    logic [c_GW-1:0] w_good_next;
    logic [c_BW-1:0] w_bad_next;

    logic            r_s1_valid;
    logic            r_s1_ok;
    logic [IW-1:0]   r_s1_k;

    state_t          r_state;
    logic            r_have_ref;
    logic [IW-1:0]   r_ref;
    logic [c_GW-1:0] r_good;
    logic [c_BW-1:0] r_bad;
    logic [IW-1:0]   r_index;
    logic            r_index_valid;
    logic            r_dir;
    logic            r_locked;
    logic            r_err_pulse;
    logic [1:0]      r_err_code;
    logic [ECW-1:0]  r_err_count;

    johnson_decode #(
        .N  (N),
        .IW (IW)
    ) u_decode (
        .i_code  (code_in),
        .o_valid (w_dec_valid),
        .o_k     (w_dec_k)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ok    <= 1'b0;
            r_s1_k     <= '0;
        end else begin
            r_s1_valid <= code_valid;
            r_s1_ok    <= w_dec_valid;
            r_s1_k     <= w_dec_k;
        end
    end

    // Modular distance from the reference, kept inside the 2N-state ring
    always_comb begin
        w_delta = r_s1_k - r_ref;
        if (r_s1_k < r_ref) begin
            w_delta = w_delta + c_NS;
        end
        if (w_delta == '0) begin
            w_step = HOLD;
        end else if (w_delta == c_ONE) begin
            w_step = FWD;
        end else if (w_delta == c_LAST) begin
            w_step = BWD;
        end else begin
            w_step = SKIP;
        end
    end

    assign w_err       = r_s1_valid && (!r_s1_ok || (r_have_ref && (w_step == SKIP)));
    assign w_good_next = r_good + c_GW'(1);
    assign w_bad_next  = r_bad + c_BW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= SEARCH;
            r_have_ref    <= 1'b0;
            r_ref         <= '0;
            r_good        <= '0;
            r_bad         <= '0;
            r_index       <= '0;
            r_index_valid <= 1'b0;
            r_dir         <= 1'b0;
            r_locked      <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_err_count   <= '0;
        end else begin
            r_index_valid <= 1'b0;
            r_err_pulse   <= 1'b0;

            if (w_err) begin
                r_err_count <= err_clr ? ECW'(1)
                             : ((&r_err_count) ? r_err_count : r_err_count + ECW'(1));
            end else if (err_clr) begin
                r_err_count <= '0;
            end

            if (r_s1_valid) begin
                if (w_err) begin
                    r_err_pulse <= 1'b1;
                    r_err_code  <= r_s1_ok ? ERR_SKIP : ERR_INVALID;
                end
                // A skip still re-anchors the reference to the newly received code
                if (r_s1_ok && (!r_have_ref || (w_step != HOLD))) begin
                    r_index       <= r_s1_k;
                    r_ref         <= r_s1_k;
                    r_index_valid <= 1'b1;
                end
                if (r_s1_ok && r_have_ref && ((w_step == FWD) || (w_step == BWD))) begin
                    r_dir <= (w_step == BWD);
                end

                case (r_state)
                    SEARCH: begin
                        if (r_s1_ok) begin
                            r_state    <= TRACK;
                            r_have_ref <= 1'b1;
                            r_good     <= '0;
                        end
                    end
                    TRACK: begin
                        if (!r_s1_ok) begin
                            r_state    <= SEARCH;
                            r_have_ref <= 1'b0;
                            r_good     <= '0;
                        end else if (w_step == SKIP) begin
                            r_good <= '0;
                        end else if (w_step != HOLD) begin
                            r_good <= w_good_next;
                            if (w_good_next == c_LOCK) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                                r_bad    <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (w_err) begin
                            if (w_bad_next == c_UNLOCK) begin
                                r_state    <= SEARCH;
                                r_locked   <= 1'b0;
                                r_have_ref <= 1'b0;
                                r_good     <= '0;
                                r_bad      <= '0;
                            end else begin
                                r_bad <= w_bad_next;
                            end
                        end else if (w_step != HOLD) begin
                            r_bad <= '0;
                        end
                    end
                    default: begin
                        r_state <= SEARCH;
                    end
                endcase
            end
        end
    end

    assign index       = r_index;
    assign index_valid = r_index_valid;
    assign dir         = r_dir;
    assign locked      = r_locked;
    assign err_pulse   = r_err_pulse;
    assign err_code    = r_err_code;
    assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_johnson_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_johnson_rx
// Description : Self-checking bench for johnson_rx with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_johnson_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       code_valid;
    logic [7:0] code_in;
    logic       err_clr;
    logic [3:0] index;
    logic       index_valid;
    logic       dir;
    logic       locked;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    johnson_rx #(
        .N          (8),
        .LOCK_CNT   (4),
        .UNLOCK_ERR (2),
        .ECW        (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .code_valid  (code_valid),
        .code_in     (code_in),
        .err_clr     (err_clr),
        .index       (index),
        .index_valid (index_valid),
        .dir         (dir),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .err_count   (err_count)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ring: position of each legal code, -1 for illegal codes
    int         tbl [256];
    logic [7:0] seq [16];

    int         m_idx, m_iv, m_dir, m_lock, m_ep, m_ecode, m_cnt;
    int         have, good, badc, refk, k, d, err;
    logic       p_v;
    logic [7:0] p_code;
    bit         started = 1'b0;

    initial begin
        logic [7:0] q;
        for (int i = 0; i < 256; i++) tbl[i] = -1;
        q = 8'h00;
        for (int i = 0; i < 16; i++) begin
            seq[i]   = q;
            tbl[q]   = i;
            q        = {q[6:0], ~q[7]};
        end
    end

    task automatic lose_one();
        badc++;
        if (badc == 2) begin
            m_lock = 0;
            have   = 0;
            good   = 0;
            badc   = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        started = 1'b1;
        if (rst) begin
            m_idx = 0; m_iv = 0; m_dir = 0; m_lock = 0; m_ep = 0; m_ecode = 0; m_cnt = 0;
            have = 0; good = 0; badc = 0; refk = 0; p_v = 1'b0; p_code = 8'h00;
        end else begin
            err  = 0;
            m_iv = 0;
            if (p_v) begin
                k = tbl[p_code];
                if (k < 0) begin
                    err = 1; m_ecode = 1;
                    if (m_lock != 0) lose_one();
                    else begin have = 0; good = 0; end
                end else if (have == 0) begin
                    refk = k; m_idx = k; m_iv = 1; have = 1; good = 0;
                end else begin
                    d = (k - refk + 16) % 16;
                    if (d == 1 || d == 15) begin
                        m_dir = (d == 15) ? 1 : 0;
                        refk = k; m_idx = k; m_iv = 1;
                        if (m_lock != 0) badc = 0;
                        else begin
                            good++;
                            if (good == 4) begin m_lock = 1; badc = 0; end
                        end
                    end else if (d != 0) begin
                        err = 1; m_ecode = 2;
                        refk = k; m_idx = k; m_iv = 1;
                        if (m_lock != 0) lose_one();
                        else good = 0;
                    end
                end
            end
            if (err != 0) m_cnt = err_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            else if (err_clr) m_cnt = 0;
            m_ep   = err;
            p_v    = code_valid;
            p_code = code_in;
        end
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("model_index",       int'(index),       m_idx);
            check("model_index_valid", int'(index_valid), m_iv);
            check("model_dir",         int'(dir),         m_dir);
            check("model_locked",      int'(locked),      m_lock);
            check("model_err_pulse",   int'(err_pulse),   m_ep);
            check("model_err_code",    int'(err_code),    m_ecode);
            check("model_err_count",   int'(err_count),   m_cnt);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            code_in = 8'($urandom);
        end
    endtask

    task automatic send(input logic [7:0] c);
        code_valid = 1'b1;
        code_in    = c;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code_in    = 8'($urandom);
    endtask

    task automatic feed(input logic [7:0] c);
        send(c);
        idle(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] wrap_codes [11];
        int pos, sel;
        wrap_codes = '{8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
        rst = 1'b1; code_valid = 1'b0; code_in = 8'h00; err_clr = 1'b0;
        idle(2);
        check("rst_index", int'(index), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_err_code", int'(err_code), 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) send(seq[$urandom_range(0, 15)]);
        rst = 1'b1;
        idle(2);
        check("midrst_index", int'(index), 0);
        check("midrst_index_valid", int'(index_valid), 0);
        rst = 1'b0;
        feed(8'h03);
        check("seed_index", int'(index), 2);
        check("seed_locked", int'(locked), 0);

        do_reset();
        send(8'h00); send(8'h01); send(8'h03); send(8'h07); send(8'h0F);
        check("prelock_locked", int'(locked), 0);
        idle(1);
        check("lock_locked", int'(locked), 1);
        check("lock_index", int'(index), 4);
        check("lock_dir", int'(dir), 0);

        foreach (wrap_codes[i]) send(wrap_codes[i]);
        idle(1);
        check("wrap_top_index", int'(index), 15);
        feed(8'h00);
        check("wrap_fwd_index", int'(index), 0);
        check("wrap_fwd_dir", int'(dir), 0);
        feed(8'h80);
        check("wrap_bwd_index", int'(index), 15);
        check("wrap_bwd_dir", int'(dir), 1);
        check("wrap_err_count", int'(err_count), 0);

        feed(8'h05);
        check("inv1_err_pulse", int'(err_pulse), 1);
        check("inv1_err_code", int'(err_code), 1);
        check("inv1_err_count", int'(err_count), 1);
        check("inv1_locked", int'(locked), 1);
        check("inv1_index", int'(index), 15);
        feed(8'h05);
        check("inv2_locked", int'(locked), 0);
        feed(8'h03);
        check("reseed_err_pulse", int'(err_pulse), 0);
        check("reseed_index", int'(index), 2);

        do_reset();
        feed(8'h00); feed(8'h01); feed(8'h03); feed(8'h0F);
        check("skip_err_code", int'(err_code), 2);
        check("skip_index", int'(index), 4);
        check("skip_err_count", int'(err_count), 1);
        feed(8'h1F); feed(8'h3F); feed(8'h7F);
        check("skip_relock_early", int'(locked), 0);
        feed(8'hFF);
        check("skip_relock", int'(locked), 1);

        do_reset();
        repeat (300) send(8'h05);
        idle(2);
        check("sat_err_count", int'(err_count), 255);
        send(8'h05);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("clr_coincident", int'(err_count), 1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("clr_alone", int'(err_count), 0);

        do_reset();
        feed(8'h07);
        send(8'h07); send(8'h07);
        idle(1);
        check("hold_index_valid", int'(index_valid), 0);
        check("hold_err_pulse", int'(err_pulse), 0);

        pos = 0;
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            err_clr    = ($urandom_range(0, 49) == 0);
            code_valid = ($urandom_range(0, 3) != 0);
            sel        = $urandom_range(0, 99);
            if (sel < 40)      pos = (pos + 1) % 16;
            else if (sel < 60) pos = (pos + 15) % 16;
            else if (sel < 85 && sel >= 75) pos = $urandom_range(0, 15);
            code_in = (sel >= 85) ? 8'($urandom) : seq[pos];
            @(posedge clk);
            #1;
        end
        rst = 1'b0; err_clr = 1'b0; code_valid = 1'b0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
